// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM and its decoder.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_JAL     = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b111;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_RS   = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic ALU_SRC_RT  = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        IC_ADD, IC_SUB, IC_JR, IC_ORI, IC_LW, IC_SW, IC_BEQ, IC_LUI, IC_JAL, IC_ILL
    } iclass_e;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational op/func -> instruction class decoder with a legal flag.
module mips_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output iclass_e    o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = IC_ILL;
        case (i_op)
            OP_SPECIAL: begin
                case (i_func)
                    FN_ADD:  o_class = IC_ADD;
                    FN_SUB:  o_class = IC_SUB;
                    FN_JR:   o_class = IC_JR;
                    default: o_class = IC_ILL;
                endcase
            end
            OP_ORI:  o_class = IC_ORI;
            OP_LW:   o_class = IC_LW;
            OP_SW:   o_class = IC_SW;
            OP_BEQ:  o_class = IC_BEQ;
            OP_LUI:  o_class = IC_LUI;
            OP_JAL:  o_class = IC_JAL;
            default: o_class = IC_ILL;
        endcase
    end

    assign o_legal = (o_class != IC_ILL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap (and freeze) on illegal instructions.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op,
    input  logic [5:0]           func,
    input  logic                 zero,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_wr,
    output logic                 pc_wr,
    output logic [1:0]           pc_src,
    output logic                 reg_wr,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src,
    output logic [1:0]           ext_op,
    output logic [2:0]           alu_ctrl,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_e                r_state;
    state_e                w_next_state;
    logic                  w_retire;
    logic [INSTRET_W-1:0]  r_instret;
    iclass_e               w_class;
    logic                  w_legal;

    mips_ctrl_decode u_decode (
        .i_op    (op),
        .i_func  (func),
        .o_class (w_class),
        .o_legal (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire)
                r_instret <= r_instret + INSTRET_ONE;
        end
    end

    // Outputs are gated by rst_n so every enable is quiet while reset is held.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_wr        = 1'b0;
        pc_wr        = 1'b0;
        pc_src       = PC_SRC_SEQ;
        reg_wr       = 1'b0;
        reg_dst      = REG_DST_RT;
        mem_to_reg   = M2R_ALU;
        alu_src      = ALU_SRC_RT;
        ext_op       = EXT_ZERO;
        alu_ctrl     = ALU_NOP;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_wr        = 1'b1;
                        pc_wr        = 1'b1;
                        pc_src       = PC_SRC_SEQ;
                        w_next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        w_next_state = S_TRAP;
`else
                        w_retire     = 1'b1;
                        w_next_state = S_FETCH;
`endif
                    end else begin
                        case (w_class)
                            IC_JAL: begin
                                reg_wr       = 1'b1;
                                reg_dst      = REG_DST_RA;
                                mem_to_reg   = M2R_PC;
                                pc_wr        = 1'b1;
                                pc_src       = PC_SRC_JUMP;
                                w_retire     = 1'b1;
                                w_next_state = S_FETCH;
                            end
                            IC_JR: begin
                                pc_wr        = 1'b1;
                                pc_src       = PC_SRC_RS;
                                w_retire     = 1'b1;
                                w_next_state = S_FETCH;
                            end
                            default: w_next_state = S_EXEC;
                        endcase
                    end
                end
                S_EXEC: begin
                    case (w_class)
                        IC_ADD: begin
                            alu_ctrl     = ALU_ADD;
                            alu_src      = ALU_SRC_RT;
                            w_next_state = S_WB;
                        end
                        IC_SUB: begin
                            alu_ctrl     = ALU_SUB;
                            alu_src      = ALU_SRC_RT;
                            w_next_state = S_WB;
                        end
                        IC_ORI: begin
                            alu_ctrl     = ALU_OR;
                            alu_src      = ALU_SRC_IMM;
                            ext_op       = EXT_ZERO;
                            w_next_state = S_WB;
                        end
                        IC_LUI: begin
                            alu_ctrl     = ALU_OR;
                            alu_src      = ALU_SRC_IMM;
                            ext_op       = EXT_LUI;
                            w_next_state = S_WB;
                        end
                        IC_LW, IC_SW: begin
                            alu_ctrl     = ALU_ADD;
                            alu_src      = ALU_SRC_IMM;
                            ext_op       = EXT_SIGN;
                            w_next_state = S_MEM;
                        end
                        IC_BEQ: begin
                            alu_ctrl = ALU_SUB;
                            alu_src  = ALU_SRC_RT;
                            if (zero) begin
                                pc_wr  = 1'b1;
                                pc_src = PC_SRC_BR;
                            end
                            w_retire     = 1'b1;
                            w_next_state = S_FETCH;
                        end
                        default: w_next_state = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (w_class == IC_SW);
                    if (dmem_ack) begin
                        if (w_class == IC_SW) begin
                            w_retire     = 1'b1;
                            w_next_state = S_FETCH;
                        end else begin
                            w_next_state = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_wr       = 1'b1;
                    reg_dst      = (w_class == IC_ADD || w_class == IC_SUB) ? REG_DST_RD : REG_DST_RT;
                    mem_to_reg   = (w_class == IC_LW) ? M2R_MEM : M2R_ALU;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP: w_next_state = S_TRAP;
`endif
                default: w_next_state = S_FETCH;
            endcase
        end
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;
    import mips_multicycle_ctrl_pkg::*;

    logic        clk, rst_n, zero, imem_ack, dmem_ack;
    logic [5:0]  op, func;
    logic        imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, alu_src;
    logic [1:0]  pc_src, reg_dst, mem_to_reg, ext_op;
    logic [2:0]  alu_ctrl, state;
    logic [31:0] instret;

    int          n_chk, n_fail;
    logic [31:0] exp_ir;

    mips_multicycle_ctrl #(.INSTRET_W(32)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func       (func),
        .zero       (zero),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .ext_op     (ext_op),
        .alu_ctrl   (alu_ctrl),
        .state      (state),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [5:0] o, input logic [5:0] f);
        op = o; func = f; imem_ack = 1'b1;
        #1;
        chk("F.state", 32'(state), 0);
        chk("F.imem_req", 32'(imem_req), 1);
        chk("F.ir_wr", 32'(ir_wr), 1);
        chk("F.pc_wr", 32'(pc_wr), 1);
        chk("F.pc_src", 32'(pc_src), 0);
        cyc();
        imem_ack = 1'b0;
    endtask

    task automatic retire_chk(input string tag);
        cyc();
        exp_ir++;
        chk({tag, ".state"}, 32'(state), 0);
        chk({tag, ".instret"}, instret, exp_ir);
    endtask

    // F, D, E, WB path for ALU-type instructions.
    task automatic alu_wb(input string tag, input logic [5:0] o, input logic [5:0] f,
                          input logic [2:0] e_alu, input logic e_src, input logic [1:0] e_ext,
                          input logic [1:0] e_dst);
        do_fetch(o, f);
        #1;
        chk({tag, ".D.state"}, 32'(state), 1);
        chk({tag, ".D.reg_wr"}, 32'(reg_wr), 0);
        chk({tag, ".D.alu_ctrl"}, 32'(alu_ctrl), 32'(ALU_NOP));
        cyc();
        chk({tag, ".E.state"}, 32'(state), 2);
        chk({tag, ".E.alu_ctrl"}, 32'(alu_ctrl), 32'(e_alu));
        chk({tag, ".E.alu_src"}, 32'(alu_src), 32'(e_src));
        chk({tag, ".E.ext_op"}, 32'(ext_op), 32'(e_ext));
        chk({tag, ".E.reg_wr"}, 32'(reg_wr), 0);
        cyc();
        chk({tag, ".W.state"}, 32'(state), 4);
        chk({tag, ".W.reg_wr"}, 32'(reg_wr), 1);
        chk({tag, ".W.reg_dst"}, 32'(reg_dst), 32'(e_dst));
        chk({tag, ".W.mem_to_reg"}, 32'(mem_to_reg), 0);
        chk({tag, ".W.instret"}, instret, exp_ir);
        retire_chk(tag);
    endtask

    task automatic do_beq(input logic z);
        do_fetch(OP_BEQ, 6'h00);
        #1;
        chk("beq.D.state", 32'(state), 1);
        cyc();
        zero = z;
        #1;
        chk("beq.E.state", 32'(state), 2);
        chk("beq.E.alu_ctrl", 32'(alu_ctrl), 32'(ALU_SUB));
        chk("beq.E.alu_src", 32'(alu_src), 0);
        chk("beq.E.pc_wr", 32'(pc_wr), 32'(z));
        chk("beq.E.pc_src", 32'(pc_src), z ? 32'd1 : 32'd0);
        retire_chk("beq");
        zero = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; exp_ir = 0;
        rst_n = 1'b0; op = '0; func = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #2;
        chk("rst.state", 32'(state), 0);
        chk("rst.instret", instret, 0);
        chk("rst.imem_req", 32'(imem_req), 0);
        chk("rst.alu_ctrl", 32'(alu_ctrl), 32'(ALU_NOP));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel.imem_req", 32'(imem_req), 1);
        chk("rel.ir_wr", 32'(ir_wr), 0);
        cyc();
        chk("wait.state", 32'(state), 0);
        chk("wait.pc_wr", 32'(pc_wr), 0);

        alu_wb("ori", OP_ORI, 6'h00, ALU_OR, 1'b1, EXT_ZERO, REG_DST_RT);
        alu_wb("lui", OP_LUI, 6'h00, ALU_OR, 1'b1, EXT_LUI, REG_DST_RT);
        alu_wb("add", OP_SPECIAL, FN_ADD, ALU_ADD, 1'b0, EXT_ZERO, REG_DST_RD);
        alu_wb("sub", OP_SPECIAL, FN_SUB, ALU_SUB, 1'b0, EXT_ZERO, REG_DST_RD);

        // lw with three dmem wait cycles; a stray dmem_ack in DECODE is ignored
        do_fetch(OP_LW, 6'h00);
        dmem_ack = 1'b1;
        #1;
        chk("lw.D.state", 32'(state), 1);
        chk("lw.D.dmem_req", 32'(dmem_req), 0);
        cyc();
        dmem_ack = 1'b0;
        #1;
        chk("lw.E.state", 32'(state), 2);
        chk("lw.E.alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
        chk("lw.E.ext_op", 32'(ext_op), 32'(EXT_SIGN));
        chk("lw.E.alu_src", 32'(alu_src), 1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw.Mw.state", 32'(state), 3);
            chk("lw.Mw.dmem_req", 32'(dmem_req), 1);
            chk("lw.Mw.dmem_we", 32'(dmem_we), 0);
            cyc();
        end
        dmem_ack = 1'b1;
        #1;
        chk("lw.Ma.state", 32'(state), 3);
        chk("lw.Ma.dmem_req", 32'(dmem_req), 1);
        cyc();
        dmem_ack = 1'b0;
        #1;
        chk("lw.W.state", 32'(state), 4);
        chk("lw.W.reg_wr", 32'(reg_wr), 1);
        chk("lw.W.mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw.W.reg_dst", 32'(reg_dst), 0);
        chk("lw.W.dmem_req", 32'(dmem_req), 0);
        retire_chk("lw");

        // sw with immediate ack
        do_fetch(OP_SW, 6'h00);
        cyc();
        chk("sw.E.ext_op", 32'(ext_op), 32'(EXT_SIGN));
        cyc();
        dmem_ack = 1'b1;
        #1;
        chk("sw.M.state", 32'(state), 3);
        chk("sw.M.dmem_we", 32'(dmem_we), 1);
        chk("sw.M.dmem_req", 32'(dmem_req), 1);
        retire_chk("sw");
        dmem_ack = 1'b0;

        do_beq(1'b1);
        do_beq(1'b0);

        do_fetch(OP_JAL, 6'h00);
        #1;
        chk("jal.D.reg_wr", 32'(reg_wr), 1);
        chk("jal.D.reg_dst", 32'(reg_dst), 2);
        chk("jal.D.mem_to_reg", 32'(mem_to_reg), 2);
        chk("jal.D.pc_wr", 32'(pc_wr), 1);
        chk("jal.D.pc_src", 32'(pc_src), 2);
        retire_chk("jal");

        do_fetch(OP_SPECIAL, FN_JR);
        #1;
        chk("jr.D.pc_wr", 32'(pc_wr), 1);
        chk("jr.D.pc_src", 32'(pc_src), 3);
        chk("jr.D.reg_wr", 32'(reg_wr), 0);
        retire_chk("jr");

        // reset in the middle of an lw MEM phase
        do_fetch(OP_LW, 6'h00);
        cyc();
        cyc();
        chk("rmem.dmem_req", 32'(dmem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rmem.dmem_req0", 32'(dmem_req), 0);
        chk("rmem.state", 32'(state), 0);
        chk("rmem.instret", instret, 0);
        exp_ir = 0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rmem.imem_req", 32'(imem_req), 1);

        // illegal opcode
        do_fetch(6'h3F, 6'h00);
        #1;
        chk("ill.D.state", 32'(state), 1);
        chk("ill.D.reg_wr", 32'(reg_wr), 0);
        chk("ill.D.pc_wr", 32'(pc_wr), 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc();
        chk("ill.T.state", 32'(state), 5);
        imem_ack = 1'b1;
        cyc();
        cyc();
        chk("ill.T.state2", 32'(state), 5);
        chk("ill.T.imem_req", 32'(imem_req), 0);
        chk("ill.T.instret", instret, exp_ir);
        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ill.T.rst", 32'(state), 0);
`else
        retire_chk("ill");
        chk("ill.imem_req", 32'(imem_req), 1);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
